// File: rtl/dice_game_ctrl.sv
// rtl/dice_game_ctrl.sv - two-player dice turn controller: debounce, roll, capture, score, winner
// Optional feature macro: DICE_BONUS_SIX_EN (a non-winning 6 grants an extra turn)
module dice_game_ctrl #(
    parameter int DEBOUNCE_CYC = 4,
    parameter int SCORE_W      = 6,
    parameter int TARGET       = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               button,
    input  logic [2:0]         throw,
    output logic               roll_en,
    output logic               player,
    output logic               result_valid,
    output logic [2:0]         result,
    output logic               throw_err,
    output logic [SCORE_W-1:0] score0,
    output logic [SCORE_W-1:0] score1,
    output logic               game_over,
    output logic               winner
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        ROLLING  = 3'd2,
        CAPTURE  = 3'd3,
        SCORE    = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               btn_meta, btn_sync;
    logic [2:0]         cap;
    logic [SCORE_W-1:0] cur_score, new_score;
    logic               face_ok, win, keep_turn;

    assign face_ok   = (cap != 3'd0) && (cap != 3'd7);
    assign cur_score = player ? score1 : score0;
    assign new_score = cur_score + SCORE_W'(cap);
    assign win       = (new_score >= SCORE_W'(TARGET));

`ifdef DICE_BONUS_SIX_EN
    assign keep_turn = (cap == 3'd6);
`else
    assign keep_turn = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // cnt counts stable pressed cycles in PRESS_DB and stable released cycles in ROLLING
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        roll_en   = 1'b0;
        case (state)
            IDLE: begin
                if (btn_sync) begin
                    if (DEBOUNCE_CYC <= 1) begin
                        state_nxt = ROLLING;
                        cnt_nxt   = '0;
                    end else begin
                        state_nxt = PRESS_DB;
                        cnt_nxt   = CNT_W'(1);
                    end
                end
            end
            PRESS_DB: begin
                if (!btn_sync) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt >= DB_LAST) begin
                    state_nxt = ROLLING;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ROLLING: begin
                roll_en = 1'b1;
                if (btn_sync) begin
                    cnt_nxt = '0;
                end else if (cnt >= DB_LAST) begin
                    state_nxt = CAPTURE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            CAPTURE: state_nxt = SCORE;
            SCORE: begin
                if (face_ok && win) state_nxt = DONE;
                else                state_nxt = IDLE;
            end
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // Synchroniser flops are reset too, so a button held across rst re-qualifies from IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta     <= 1'b0;
            btn_sync     <= 1'b0;
            cap          <= 3'd0;
            result       <= 3'd0;
            result_valid <= 1'b0;
            throw_err    <= 1'b0;
            score0       <= '0;
            score1       <= '0;
            player       <= 1'b0;
            game_over    <= 1'b0;
            winner       <= 1'b0;
        end else begin
            btn_meta     <= button;
            btn_sync     <= btn_meta;
            result_valid <= 1'b0;
            throw_err    <= 1'b0;
            if (state == CAPTURE) cap <= throw;
            if (state == SCORE) begin
                if (face_ok) begin
                    result       <= cap;
                    result_valid <= 1'b1;
                    if (player) score1 <= new_score;
                    else        score0 <= new_score;
                    if (win) begin
                        winner    <= player;
                        game_over <= 1'b1;
                    end else if (!keep_turn) begin
                        player <= ~player;
                    end
                end else begin
                    throw_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_dice_game_ctrl.sv
// tb/tb_dice_game_ctrl.sv - directed self-checking bench for dice_game_ctrl
module tb_dice_game_ctrl;

    logic       clk = 1'b0;
    logic       rst, button;
    logic [2:0] throw;
    logic       roll_en, player, result_valid, throw_err, game_over, winner;
    logic [2:0] result;
    logic [5:0] score0, score1;

    int vectors = 0;
    int miscompares = 0;

`ifdef DICE_BONUS_SIX_EN
    localparam logic BONUS = 1'b1;
`else
    localparam logic BONUS = 1'b0;
`endif

    dice_game_ctrl #(.DEBOUNCE_CYC(4), .SCORE_W(6), .TARGET(10)) dut (
        .clk(clk), .rst(rst), .button(button), .throw(throw),
        .roll_en(roll_en), .player(player), .result_valid(result_valid),
        .result(result), .throw_err(throw_err), .score0(score0), .score1(score1),
        .game_over(game_over), .winner(winner)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic turn(input logic [2:0] face);
        bit seen;
        seen = 0;
        button = 1'b1;
        repeat (8) tick();
        throw  = face;
        button = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            if (result_valid || throw_err) seen = 1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL turn_timeout face=%0d: got no pulse in 30 cycles, expected result_valid or throw_err", face);
        end
    endtask

    task automatic test_reset;
        bit rolled, pulsed;
        rst = 1'b1; button = 1'b0; throw = 3'd0;
        tick();
        rst = 1'b0;
        vectors++;
        if ({roll_en, player, result_valid, throw_err, game_over, winner} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000", {roll_en, player, result_valid, throw_err, game_over, winner});
        end
        vectors++;
        if (result !== 3'd0) begin
            miscompares++; $display("FAIL reset_result: got %0d expected 0", result);
        end
        vectors++;
        if ({score0, score1} !== 12'd0) begin
            miscompares++; $display("FAIL reset_scores: got %0d/%0d expected 0/0", score0, score1);
        end
        rolled = 0; pulsed = 0;
        for (int p = 0; p < 3; p++) begin
            button = 1'b1;
            repeat (3) begin tick(); if (roll_en) rolled = 1; end
            button = 1'b0;
            repeat (4) begin tick(); if (roll_en) rolled = 1; if (result_valid || throw_err) pulsed = 1; end
        end
        vectors++;
        if (rolled !== 1'b0) begin
            miscompares++; $display("FAIL short_pulse_roll: got roll_en=1 seen expected never");
        end
        vectors++;
        if (pulsed !== 1'b0) begin
            miscompares++; $display("FAIL short_pulse_result: got a pulse expected none");
        end
    endtask

    task automatic test_first_throw;
        int lat;
        bit seen;
        button = 1'b1; throw = 3'd0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 5) begin
                vectors++;
                if (roll_en !== 1'b0) begin miscompares++; $display("FAIL roll_early: got %b expected 0 at cycle 5", roll_en); end
            end
            if (k == 6 || k == 10) begin
                vectors++;
                if (roll_en !== 1'b1) begin miscompares++; $display("FAIL roll_start: got %b expected 1 at cycle %0d", roll_en, k); end
            end
        end
        throw = 3'd5; button = 1'b0;
        seen = 0; lat = 0;
        for (int i = 1; i <= 30 && !seen; i++) begin
            tick();
            if (result_valid) begin seen = 1; lat = i; end
        end
        vectors++;
        if (lat !== 8) begin miscompares++; $display("FAIL release_latency: got %0d expected 8", lat); end
        vectors++;
        if (result !== 3'd5) begin miscompares++; $display("FAIL first_result: got %0d expected 5", result); end
        vectors++;
        if (score0 !== 6'd5 || score1 !== 6'd0) begin miscompares++; $display("FAIL first_scores: got %0d/%0d expected 5/0", score0, score1); end
        vectors++;
        if (player !== 1'b1) begin miscompares++; $display("FAIL first_player: got %b expected 1", player); end
        tick();
        vectors++;
        if (result_valid !== 1'b0) begin miscompares++; $display("FAIL valid_width: got %b expected 0", result_valid); end
    endtask

    task automatic test_bounce;
        bit dropped, pulsed, seen;
        button = 1'b1;
        repeat (8) tick();
        dropped = 0; pulsed = 0;
        button = 1'b0;
        repeat (2) begin tick(); if (!roll_en) dropped = 1; if (result_valid) pulsed = 1; end
        button = 1'b1;
        repeat (6) begin tick(); if (!roll_en) dropped = 1; if (result_valid) pulsed = 1; end
        vectors++;
        if (dropped !== 1'b0) begin miscompares++; $display("FAIL bounce_roll: got roll_en drop expected steady 1"); end
        vectors++;
        if (pulsed !== 1'b0) begin miscompares++; $display("FAIL bounce_capture: got capture expected none"); end
        throw = 3'd1; button = 1'b0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin tick(); if (result_valid) seen = 1; end
        vectors++;
        if (score1 !== 6'd1 || result !== 3'd1 || player !== 1'b0) begin
            miscompares++; $display("FAIL bounce_score: got s1=%0d r=%0d p=%b expected s1=1 r=1 p=0", score1, result, player);
        end
    endtask

    task automatic test_throw_err;
        turn(3'd7);
        vectors++;
        if (throw_err !== 1'b1 || result_valid !== 1'b0) begin
            miscompares++; $display("FAIL err7_pulse: got err=%b valid=%b expected err=1 valid=0", throw_err, result_valid);
        end
        vectors++;
        if (score0 !== 6'd5 || score1 !== 6'd1 || player !== 1'b0 || result !== 3'd1) begin
            miscompares++; $display("FAIL err7_state: got s0=%0d s1=%0d p=%b r=%0d expected 5 1 0 1", score0, score1, player, result);
        end
        tick();
        vectors++;
        if (throw_err !== 1'b0) begin miscompares++; $display("FAIL err_width: got %b expected 0", throw_err); end
        turn(3'd0);
        vectors++;
        if (throw_err !== 1'b1 || score0 !== 6'd5 || player !== 1'b0) begin
            miscompares++; $display("FAIL err0: got err=%b s0=%0d p=%b expected 1 5 0", throw_err, score0, player);
        end
    endtask

    task automatic test_bonus_six;
        turn(3'd1);
        vectors++;
        if (score0 !== 6'd6 || player !== 1'b1) begin
            miscompares++; $display("FAIL min_face: got s0=%0d p=%b expected 6 1", score0, player);
        end
        turn(3'd6);
        vectors++;
        if (score1 !== 6'd7 || player !== BONUS) begin
            miscompares++; $display("FAIL six_turn: got s1=%0d p=%b expected s1=7 p=%b", score1, player, BONUS);
        end
`ifdef DICE_BONUS_SIX_EN
        turn(3'd1);
        vectors++;
        if (score1 !== 6'd8 || player !== 1'b0) begin
            miscompares++; $display("FAIL bonus_followup: got s1=%0d p=%b expected 8 0", score1, player);
        end
`endif
    endtask

    task automatic test_win;
        bit rolled;
        logic [5:0] s1_before;
        s1_before = score1;
        turn(3'd4);
        vectors++;
        if (score0 !== 6'd10 || result !== 3'd4 || result_valid !== 1'b1) begin
            miscompares++; $display("FAIL win_score: got s0=%0d r=%0d v=%b expected 10 4 1", score0, result, result_valid);
        end
        vectors++;
        if (game_over !== 1'b1 || winner !== 1'b0) begin
            miscompares++; $display("FAIL win_flags: got go=%b w=%b expected 1 0", game_over, winner);
        end
        rolled = 0;
        button = 1'b1;
        repeat (12) begin tick(); if (roll_en) rolled = 1; end
        button = 1'b0;
        repeat (10) begin tick(); if (roll_en) rolled = 1; end
        vectors++;
        if (rolled !== 1'b0) begin miscompares++; $display("FAIL done_roll: got roll_en=1 expected 0"); end
        vectors++;
        if (score0 !== 6'd10 || score1 !== s1_before || game_over !== 1'b1) begin
            miscompares++; $display("FAIL done_frozen: got s0=%0d s1=%0d go=%b expected 10 %0d 1", score0, score1, game_over, s1_before);
        end
    endtask

    task automatic test_reset_mid_roll;
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (game_over !== 1'b0 || score0 !== 6'd0) begin
            miscompares++; $display("FAIL rerst_clear: got go=%b s0=%0d expected 0 0", game_over, score0);
        end
        button = 1'b1;
        repeat (8) tick();
        vectors++;
        if (roll_en !== 1'b1) begin miscompares++; $display("FAIL midroll_setup: got %b expected 1", roll_en); end
        rst = 1'b1; tick(); rst = 1'b0;
        vectors++;
        if (roll_en !== 1'b0 || player !== 1'b0 || score1 !== 6'd0) begin
            miscompares++; $display("FAIL midroll_reset: got roll=%b p=%b s1=%0d expected 0 0 0", roll_en, player, score1);
        end
        repeat (3) tick();
        vectors++;
        if (roll_en !== 1'b0) begin miscompares++; $display("FAIL held_requalify: got %b expected 0", roll_en); end
        button = 1'b0; throw = 3'd2;
        repeat (20) tick();
    endtask

    initial begin
        test_reset();
        test_first_throw();
        test_bounce();
        test_throw_err();
        test_bonus_six();
        test_win();
        test_reset_mid_roll();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
